// File: rtl/sd4_mac_pkg.sv
// Shared constants and types for the SD4_MAC accumulator / requantiser path.
package sd4_mac_pkg;

  localparam int SUM_W     = 20;
  localparam int LOD_GROUP = 4;

  // Ceiling log2, usable in constant expressions; clog2_f(1) = 0.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int LOD_IDX_W = clog2_f(SUM_W);

  typedef struct packed {
    logic [LOD_IDX_W-1:0] idx;
    logic                 zero;
    logic                 neg;
    logic [SUM_W-1:0]     norm;
  } lod_result_t;

endpackage

// File: rtl/lod_group.sv
// Combinational leading-one finder for one G-bit group: any-one flag and MSB-priority index.
module lod_group
  import sd4_mac_pkg::*;
#(
  parameter  int G     = 4,
  localparam int LOC_W = (G > 1) ? clog2_f(G) : 1
) (
  input  logic [G-1:0]     grp,
  output logic             nz,
  output logic [LOC_W-1:0] loc
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    nz  = |grp;
    loc = '0;
    for (int i = 0; i < G; i++) begin
      if (grp[i]) loc = LOC_W'(i);
    end
  end

endmodule

// File: rtl/leadingone_detector_pipe.sv
// Two-stage leading-one detector and normaliser with a stall-propagating valid/ready pipeline.
module leadingone_detector_pipe
  import sd4_mac_pkg::*;
#(
  parameter  int W     = SUM_W,
  parameter  int G     = LOD_GROUP,
  localparam int IDX_W = clog2_f(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_sum,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_zero,
  output logic             out_neg,
  output logic [W-1:0]     out_norm
);

  localparam int NG    = (W + G - 1) / G;
  localparam int PW    = NG * G;
  localparam int LOC_W = (G > 1) ? clog2_f(G) : 1;

  logic s1_valid;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // ---------------- Stage 1: sign, magnitude, per-group search ----------------
  logic                       neg_d;
  logic [W-1:0]               mag_d;
  logic [PW-1:0]              mag_pad;
  logic [NG-1:0]              nz_d;
  logic [NG-1:0][LOC_W-1:0]   loc_d;

  assign neg_d = in_signed & in_sum[W-1];
  // The most-negative input wraps to 2^(W-1), which is exactly its magnitude.
  assign mag_d = neg_d ? (~in_sum + W'(1)) : in_sum;

  always_comb begin
    mag_pad         = '0;
    mag_pad[W-1:0]  = mag_d;
  end

  for (genvar k = 0; k < NG; k++) begin : g_grp
    lod_group #(.G(G)) u_lod_group (
      .grp (mag_pad[k*G +: G]),
      .nz  (nz_d[k]),
      .loc (loc_d[k])
    );
  end

  logic [W-1:0]             s1_mag;
  logic                     s1_neg;
  logic [NG-1:0]            s1_nz;
  logic [NG-1:0][LOC_W-1:0] s1_loc;

  // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: the payload has no reset; it is only ever consumed while s1_valid is set.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_mag <= mag_d;
      s1_neg <= neg_d;
      s1_nz  <= nz_d;
      s1_loc <= loc_d;
    end
  end

  // ---------------- Stage 2: group select and normalising shift ----------------
  logic             found;
  logic [IDX_W-1:0] sel_idx;
  logic [W-1:0]     norm_d;

  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < NG; k++) begin
      if (s1_nz[k]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(k * G) + IDX_W'(s1_loc[k]);
      end
    end
    norm_d = found ? (s1_mag << (IDX_W'(W - 1) - sel_idx)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
      out_norm  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_idx  <= sel_idx;
        out_zero <= !found;
        out_neg  <= s1_neg & found;
        out_norm <= norm_d;
      end
    end
  end

endmodule

// File: tb/tb_leadingone_detector_pipe.sv
// Directed bench: W=20 handshake/edge/reset cases plus W=8,G=1 and W=17,G=4 sweeps against a bit-scan model.
module tb_leadingone_detector_pipe;
  import sd4_mac_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- W=20, G=4 main instance ----------------
  logic        in_valid = 1'b0, in_ready, in_signed = 1'b0;
  logic [19:0] in_sum = '0;
  logic        out_valid, out_ready = 1'b1, out_zero, out_neg;
  logic [4:0]  out_idx;
  logic [19:0] out_norm;

  leadingone_detector_pipe #(.W(20), .G(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_zero(out_zero),
    .out_neg(out_neg), .out_norm(out_norm)
  );

  // ---------------- W=8, G=1 sweep instance ----------------
  logic       s8_in_valid = 1'b0, s8_in_ready, s8_in_signed = 1'b0;
  logic [7:0] s8_in_sum = '0;
  logic       s8_out_valid, s8_out_zero, s8_out_neg;
  logic [2:0] s8_out_idx;
  logic [7:0] s8_out_norm;

  leadingone_detector_pipe #(.W(8), .G(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(s8_in_valid), .in_ready(s8_in_ready),
    .in_sum(s8_in_sum), .in_signed(s8_in_signed), .out_valid(s8_out_valid),
    .out_ready(1'b1), .out_idx(s8_out_idx), .out_zero(s8_out_zero),
    .out_neg(s8_out_neg), .out_norm(s8_out_norm)
  );

  // ---------------- W=17, G=4 sweep instance (padded top group) ----------------
  logic        s17_in_valid = 1'b0, s17_in_ready, s17_in_signed = 1'b0;
  logic [16:0] s17_in_sum = '0;
  logic        s17_out_valid, s17_out_zero, s17_out_neg;
  logic [4:0]  s17_out_idx;
  logic [16:0] s17_out_norm;

  leadingone_detector_pipe #(.W(17), .G(4)) dut17 (
    .clk(clk), .rst_n(rst_n), .in_valid(s17_in_valid), .in_ready(s17_in_ready),
    .in_sum(s17_in_sum), .in_signed(s17_in_signed), .out_valid(s17_out_valid),
    .out_ready(1'b1), .out_idx(s17_out_idx), .out_zero(s17_out_zero),
    .out_neg(s17_out_neg), .out_norm(s17_out_norm)
  );

  // Reference: plain bit scan of the magnitude, independent of grouping.
  function automatic void lod_ref(input int w, input logic [31:0] sum, input logic sgn,
                                  output logic [31:0] idx, output logic zero,
                                  output logic neg, output logic [31:0] norm);
    logic [31:0] mask;
    logic [31:0] mag;
    mask = (32'd1 << w) - 32'd1;
    neg  = sgn & sum[w-1];
    mag  = neg ? ((~sum + 32'd1) & mask) : (sum & mask);
    idx  = '0;
    zero = 1'b1;
    for (int b = 0; b < w; b++) begin
      if (mag[b]) begin
        idx  = 32'(b);
        zero = 1'b0;
      end
    end
    norm = zero ? 32'd0 : ((mag << (w - 1 - int'(idx))) & mask);
  endfunction

  // ---------------- Directed vector table for the main instance ----------------
  logic [19:0] v_sum [16];
  logic        v_sgn [16];
  lod_result_t v_exp [16];
  int          n_vec = 0;

  task automatic add_vec(input logic [19:0] s, input logic sg, input logic [4:0] idx,
                         input logic z, input logic ng, input logic [19:0] nrm);
    v_sum[n_vec] = s;
    v_sgn[n_vec] = sg;
    v_exp[n_vec] = '{idx: idx, zero: z, neg: ng, norm: nrm};
    n_vec++;
  endtask

  // Streams the table, starting at a negedge with an empty pipe; out_ready drops for
  // stall_len cycles from cycle stall_from. Head-of-line result is checked every cycle it is shown.
  task automatic run_stream(input string tag, input int stall_from, input int stall_len,
                            input bit chk_rdy);
    int ni, no, first, last;
    bit stall;
    ni = 0; no = 0; first = -1; last = -1;
    for (int c = 0; c < 40 && no < n_vec; c++) begin
      stall     = (c >= stall_from) && (c < stall_from + stall_len);
      out_ready = !stall;
      in_valid  = (ni < n_vec);
      in_sum    = in_valid ? v_sum[ni] : 20'h0;
      in_signed = in_valid ? v_sgn[ni] : 1'b0;
      #1;
      if (chk_rdy && c < stall_from + stall_len + 2)
        check({tag, "_in_ready"}, in_ready, !stall);
      if (out_valid) begin
        if (first < 0) first = c;
        check({tag, "_idx"},  out_idx,  v_exp[no].idx);
        check({tag, "_zero"}, out_zero, v_exp[no].zero);
        check({tag, "_neg"},  out_neg,  v_exp[no].neg);
        check({tag, "_norm"}, out_norm, v_exp[no].norm);
        if (out_ready) begin
          no++;
          last = c;
        end
      end
      if (in_valid && in_ready) ni++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check({tag, "_first_valid_cycle"}, first, 2);
    check({tag, "_last_emit_cycle"}, last, n_vec + 1 + stall_len);
    check({tag, "_emitted"}, no, n_vec);
    check({tag, "_drained"}, out_valid, 1'b0);
    n_vec = 0;
    @(negedge clk);
  endtask

  task automatic sweep8();
    logic [31:0] e_idx, e_norm;
    logic        e_zero, e_neg;
    for (int c = 0; c < 514; c++) begin
      s8_in_valid  = (c < 512);
      s8_in_sum    = 8'(c);
      s8_in_signed = c[8];
      #1;
      if (c >= 2) begin
        lod_ref(8, 32'((c - 2) & 255), 1'((c - 2) >> 8), e_idx, e_zero, e_neg, e_norm);
        check("w8_valid", s8_out_valid, 1'b1);
        check("w8_idx",   s8_out_idx,   e_idx);
        check("w8_zero",  s8_out_zero,  e_zero);
        check("w8_neg",   s8_out_neg,   e_neg);
        check("w8_norm",  s8_out_norm,  e_norm);
      end
      @(negedge clk);
    end
    s8_in_valid = 1'b0;
  endtask

  task automatic sweep17();
    logic [16:0] r_sum [300];
    logic        r_sgn [300];
    logic [31:0] e_idx, e_norm;
    logic        e_zero, e_neg;
    for (int i = 0; i < 300; i++) begin
      r_sum[i] = 17'($urandom) >> $urandom_range(0, 16);
      r_sgn[i] = 1'($urandom_range(0, 1));
    end
    r_sum[0] = 17'h00000; r_sgn[0] = 1'b1;
    r_sum[1] = 17'h10000; r_sgn[1] = 1'b1;
    r_sum[2] = 17'h10000; r_sgn[2] = 1'b0;
    r_sum[3] = 17'h1FFFF; r_sgn[3] = 1'b1;
    for (int c = 0; c < 302; c++) begin
      s17_in_valid  = (c < 300);
      s17_in_sum    = (c < 300) ? r_sum[c] : 17'h0;
      s17_in_signed = (c < 300) ? r_sgn[c] : 1'b0;
      #1;
      if (c >= 2) begin
        lod_ref(17, 32'(r_sum[c-2]), r_sgn[c-2], e_idx, e_zero, e_neg, e_norm);
        check("w17_valid", s17_out_valid, 1'b1);
        check("w17_idx",   s17_out_idx,   e_idx);
        check("w17_zero",  s17_out_zero,  e_zero);
        check("w17_neg",   s17_out_neg,   e_neg);
        check("w17_norm",  s17_out_norm,  e_norm);
      end
      @(negedge clk);
    end
    s17_in_valid = 1'b0;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_norm",  out_norm,  20'h0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Unsigned basics, back to back.
    add_vec(20'h80000, 1'b0, 5'd19, 1'b0, 1'b0, 20'h80000);
    add_vec(20'h00001, 1'b0, 5'd0,  1'b0, 1'b0, 20'h80000);
    add_vec(20'h0A000, 1'b0, 5'd15, 1'b0, 1'b0, 20'hA0000);
    run_stream("basic", 1000, 0, 1'b0);

    // Zero and signed edge cases.
    add_vec(20'h00000, 1'b0, 5'd0,  1'b1, 1'b0, 20'h00000);
    add_vec(20'h00000, 1'b1, 5'd0,  1'b1, 1'b0, 20'h00000);
    add_vec(20'h80000, 1'b1, 5'd19, 1'b0, 1'b1, 20'h80000);
    add_vec(20'hFFFFF, 1'b1, 5'd0,  1'b0, 1'b1, 20'h80000);
    add_vec(20'hFFFFF, 1'b0, 5'd19, 1'b0, 1'b0, 20'hFFFFF);
    add_vec(20'h00003, 1'b1, 5'd1,  1'b0, 1'b0, 20'hC0000);
    add_vec(20'h7FFFF, 1'b1, 5'd18, 1'b0, 1'b0, 20'hFFFFE);
    run_stream("edge", 1000, 0, 1'b0);

    // Backpressure: out_ready low for cycles 3..6 while five inputs stream.
    add_vec(20'h00010, 1'b0, 5'd4,  1'b0, 1'b0, 20'h80000);
    add_vec(20'h00300, 1'b0, 5'd9,  1'b0, 1'b0, 20'hC0000);
    add_vec(20'h40000, 1'b0, 5'd18, 1'b0, 1'b0, 20'h80000);
    add_vec(20'hFFFF0, 1'b1, 5'd4,  1'b0, 1'b1, 20'h80000);
    add_vec(20'h12345, 1'b0, 5'd16, 1'b0, 1'b0, 20'h91A28);
    run_stream("bp", 3, 4, 1'b1);

    // Reset mid-stall with both stages full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sum    = 20'h80001;
    in_signed = 1'b1;
    @(negedge clk);
    in_sum    = 20'h00005;
    in_signed = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_valid", out_valid, 1'b1);
    check("pre_rst_idx",   out_idx,   5'd18);
    check("pre_rst_norm",  out_norm,  20'hFFFFE);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_idx",   out_idx,   5'd0);
    check("async_rst_zero",  out_zero,  1'b0);
    check("async_rst_neg",   out_neg,   1'b0);
    check("async_rst_norm",  out_norm,  20'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("post_rst_no_stale", out_valid, 1'b0);
      check("post_rst_in_ready", in_ready, 1'b1);
    end
    @(negedge clk);

    // Parameter sweeps.
    sweep8();
    sweep17();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
